tdoa_capture: RTL

Measures the arrival-time differences of one acoustic event across the four microphones of the array and hands them to the position solver. It timestamps the first rising edge of each microphone onset flag on a 0.1 ms tick grid. It then forms signed delays relative to microphone 1 and raises `ena` once the delays are stable. It sits between the per-microphone onset detectors and the position calculator, producing the `delay12/13/14` + `ena` interface that the solver consumes.

---
 rtl/tdoa_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tdoa_capture.sv
// Four-microphone arrival-time capture: timestamps the first onset edge of each mic on a
// tick grid, then presents signed delays relative to mic1 with an ena strobe.
module tdoa_capture #(
    parameter int CLK_DIV = 5000,
    parameter int TIMEOUT = 64,
    parameter int HOLDOFF = 100,
    parameter int ENA_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         onset,
    output logic signed [15:0] delay12,
    output logic signed [15:0] delay13,
    output logic signed [15:0] delay14,
    output logic               ena,
    output logic               busy,
    output logic               timeout_err
);

    // The prescaler doubles as the strobe-length counter, so it must hold either range.
    localparam int CNT_MAX = (CLK_DIV > ENA_LEN) ? CLK_DIV : ENA_LEN;
    localparam int PW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPUTE,
        S_STROBE,
        S_HOLDOFF
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         onset_q;
    logic [3:0]         captured_q, captured_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [15:0]        tick_q, tick_d;
    logic [3:0][15:0]   ts_q, ts_d;
    logic signed [15:0] d12_q, d12_d, d13_q, d13_d, d14_q, d14_d;
    logic               ena_q, ena_d;
    logic               timeout_q, timeout_d;

    logic [3:0]         rise;
    logic [3:0]         new_cap;
    logic               presc_wrap;

    assign rise       = onset & ~onset_q;
    assign new_cap    = rise & ~captured_q;
    assign presc_wrap = (presc_q == PW'(CLK_DIV - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        captured_d = captured_q;
        presc_d    = presc_q;
        tick_d     = tick_q;
        ts_d       = ts_q;
        d12_d      = d12_q;
        d13_d      = d13_q;
        d14_d      = d14_q;
        ena_d      = (state_q == S_STROBE);
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|rise) begin
                    presc_d    = '0;
                    tick_d     = '0;
                    captured_d = rise;
                    for (int i = 0; i < 4; i++) begin
                        if (rise[i]) ts_d[i] = '0;
                    end
                    state_d = (&rise) ? S_COMPUTE : S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (presc_wrap) begin
                    presc_d = '0;
                    if (tick_q != 16'(TIMEOUT)) tick_d = tick_q + 16'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                for (int i = 0; i < 4; i++) begin
                    if (new_cap[i]) ts_d[i] = tick_q;
                end
                captured_d = captured_q | new_cap;

                // A completing edge in the timeout cycle keeps the capture alive one more cycle.
                if (&captured_q) begin
                    state_d = S_COMPUTE;
                end else if ((tick_q == 16'(TIMEOUT)) && !(&captured_d)) begin
                    timeout_d = 1'b1;
                    presc_d   = '0;
                    tick_d    = '0;
                    state_d   = S_HOLDOFF;
                end
            end

            S_COMPUTE: begin
                d12_d   = $signed(ts_q[1] - ts_q[0]);
                d13_d   = $signed(ts_q[2] - ts_q[0]);
                d14_d   = $signed(ts_q[3] - ts_q[0]);
                presc_d = '0;
                state_d = S_STROBE;
            end

            S_STROBE: begin
                if (presc_q == PW'(ENA_LEN - 1)) begin
                    presc_d = '0;
                    tick_d  = '0;
                    state_d = S_HOLDOFF;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            S_HOLDOFF: begin
                if (tick_q == 16'(HOLDOFF)) begin
                    state_d = S_IDLE;
                end else if (presc_wrap) begin
                    presc_d = '0;
                    tick_d  = tick_q + 16'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            onset_q    <= '0;
            captured_q <= '0;
            presc_q    <= '0;
            tick_q     <= '0;
            ts_q       <= '0;
            d12_q      <= '0;
            d13_q      <= '0;
            d14_q      <= '0;
            ena_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            onset_q    <= onset;
            captured_q <= captured_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            ts_q       <= ts_d;
            d12_q      <= d12_d;
            d13_q      <= d13_d;
            d14_q      <= d14_d;
            ena_q      <= ena_d;
            timeout_q  <= timeout_d;
        end
    end

    assign delay12     = d12_q;
    assign delay13     = d13_q;
    assign delay14     = d14_q;
    assign ena         = ena_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != S_IDLE);

endmodule
